// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential unsigned non-restoring divider
//
// Purpose:
//   Divides an unsigned WIDTH-bit dividend by an unsigned WIDTH-bit divisor,
//   one quotient bit per clock, using the non-restoring algorithm with a
//   WIDTH+1 bit signed partial remainder and a final remainder correction.
//   Operands arrive on a shared bus: dividend the cycle after start is seen,
//   divisor the cycle after that.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides all other inputs
//   start        level request, only sampled while idle
//   data_in      shared operand bus (dividend, then divisor)
//   quotient     registered quotient, updated on entering DONE
//   remainder    registered remainder, updated on entering DONE
//   done         high while the result is being presented
//   busy         high while an operation is in progress
//   div_by_zero  high when the last operation had a zero divisor

module nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_Q  = 3'd1,
        S_LOAD_M  = 3'd2,
        S_ITER    = 3'd3,
        S_CORRECT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // Datapath helpers for one iteration and for the final correction.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   a_step;
    logic [WIDTH:0]   a_fix;

    assign m_ext   = {1'b0, m_q};
    // Shift {A,Q} left by one: the MSB of Q moves into the LSB of A.
    assign a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    // The sign of the partial remainder before the shift picks subtract/add.
    assign a_step  = a_q[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);
    // A negative final partial remainder is restored once by adding M back.
    assign a_fix   = a_q[WIDTH] ? (a_q + m_ext) : a_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                a_d   = '0;
                cnt_d = CW'(WIDTH);
                if (start) begin
                    state_d = S_LOAD_Q;
                end
            end

            S_LOAD_Q: begin
                q_d     = data_in;
                state_d = S_LOAD_M;
            end

            S_LOAD_M: begin
                m_d = data_in;
                if (data_in == '0) begin
                    // Divide by zero: report all-ones quotient and pass the
                    // dividend through as the remainder, skipping iteration.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                a_d   = a_step;
                q_d   = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
                cnt_d = cnt_q - CW'(1);
                // cnt_q==1 means this step brings the count to zero.
                if (cnt_q == CW'(1)) begin
                    state_d = S_CORRECT;
                end
            end

            S_CORRECT: begin
                a_d         = a_fix;
                quotient_d  = q_q;
                remainder_d = a_fix[WIDTH-1:0];
                dbz_d       = 1'b0;
                state_d     = S_DONE;
            end

            S_DONE: begin
                // Holding start keeps us here so one request yields one result.
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done = 1'b0;
        busy = 1'b0;
        unique case (state_q)
            S_LOAD_Q, S_LOAD_M, S_ITER, S_CORRECT: busy = 1'b1;
            S_DONE:                                done = 1'b1;
            default:                               ;
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - self-checking bench for nonrestoring_divider

module tb_nonrestoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    int checks;
    int failures;

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one operation starting from IDLE. abort_at>0 asserts rst so that it
    // is sampled on edge k+abort_at+1 and checks the cleared outputs instead.
    task automatic do_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input int abort_at, input bit hold);
        int           edges;
        bit           seen;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           elat;

        if (dv == 0) begin
            eq = '1; er = dd; edz = 1'b1; elat = 2;
        end else begin
            eq = W'(int'(dd) / int'(dv));
            er = W'(int'(dd) % int'(dv));
            edz = 1'b0; elat = W + 3;
        end

        @(negedge clk);
        start   = 1'b1;
        data_in = W'($urandom);
        @(posedge clk);
        edges = 0;
        seen  = 0;
        while (edges < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            chk("busy_during_op", {31'd0, busy}, 32'd1);
            if (edges == 0)      data_in = dd;
            else if (edges == 1) data_in = dv;
            else                 data_in = W'($urandom);
            start = 1'($urandom);
            if (abort_at != 0 && edges == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_quot", {24'd0, quotient}, 32'd0);
                chk("rst_rem", {24'd0, remainder}, 32'd0);
                chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
                @(negedge clk);
                chk("rst_no_restart", {31'd0, busy | done}, 32'd0);
                return;
            end
            @(posedge clk);
            edges++;
        end

        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            chk("latency", edges, elat);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("quotient", {24'd0, quotient}, {24'd0, eq});
            chk("remainder", {24'd0, remainder}, {24'd0, er});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        end

        start = hold;
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_done_low", {31'd0, done}, 32'd0);
            chk("idle_quot_held", {24'd0, quotient}, {24'd0, eq});
            chk("idle_rem_held", {24'd0, remainder}, {24'd0, er});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_quot", {24'd0, quotient}, 32'd0);
        chk("reset_rem", {24'd0, remainder}, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;

        do_op(8'd13, 8'd4, 0, 0);
        do_op(8'd200, 8'd13, 0, 0);
        do_op(8'd255, 8'd1, 0, 0);
        do_op(8'd0, 8'd7, 0, 0);
        do_op(8'd7, 8'd0, 0, 0);
        do_op(8'd9, 8'd3, 0, 0);
        do_op(8'd255, 8'd255, 0, 0);
        do_op(8'd1, 8'd255, 0, 0);

        // start held high after a result: no retrigger, results stable.
        do_op(8'd13, 8'd4, 0, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            data_in = W'($urandom);
            if (i % 10 == 9) begin
                chk("hold_done", {31'd0, done}, 32'd1);
                chk("hold_busy", {31'd0, busy}, 32'd0);
                chk("hold_quot", {24'd0, quotient}, 32'd3);
                chk("hold_rem", {24'd0, remainder}, 32'd1);
            end
        end
        start = 1'b0;
        @(posedge clk);
        do_op(8'd100, 8'd7, 0, 0);

        // Reset during the 4th ITER cycle, then a clean operation.
        do_op(8'd200, 8'd13, 5, 0);
        do_op(8'd50, 8'd6, 0, 0);

        for (int n = 0; n < 300; n++) begin
            do_op(W'($urandom), W'($urandom_range(1, 255)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
